// File: rtl/seg7_num_fmt.sv
// Sequential binary-to-BCD formatter (shift-and-add-3, one bit per clock)
// driving per-digit 7-segment char_ids, with leading-zero blanking and saturation.
module seg7_num_fmt #(
    parameter int IN_W   = 11,
    parameter int DIGITS = 4
) (
    input  logic                clk27,
    input  logic                reset_n,
    input  logic                start,
    input  logic [IN_W-1:0]     value,
    input  logic                blank_lz,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] char_ids,
    output logic                overflow
);

    // Enough BCD digits for any IN_W-bit value, and never fewer than DIGITS
    localparam int NB = (IN_W + 2) / 3;
    localparam int ND = (NB > DIGITS) ? NB : DIGITS;
    localparam int BW = 4 * ND;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FMT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [BW-1:0]       bcd;
    logic [BW-1:0]       bcd_adj;
    logic [IN_W-1:0]     shreg;
    logic [IN_W-1:0]     vlat;
    logic                blank_q;
    logic [CW-1:0]       cnt;
    logic                last_bit;
    logic                ov_nx;
    logic [4*DIGITS-1:0] fmt_ids;

    assign last_bit = (cnt == CW'(IN_W - 1));
    assign ov_nx    = (32'(vlat) >= LIMIT);

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last_bit) state_nx = FMT;
            FMT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Scan from the MSD down; the LSD is always shown
    always_comb begin
        logic       seen;
        logic [3:0] d;
        seen    = 1'b0;
        d       = 4'd0;
        fmt_ids = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (ov_nx) begin
                fmt_ids[4*i +: 4] = 4'h9;
            end else if (blank_q && !seen && d == 4'd0 && i != 0) begin
                fmt_ids[4*i +: 4] = 4'hF;
            end else begin
                fmt_ids[4*i +: 4] = d;
                seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            char_ids <= '1;
            overflow <= 1'b0;
            bcd      <= '0;
            shreg    <= '0;
            vlat     <= '0;
            blank_q  <= 1'b0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vlat    <= value;
                        shreg   <= value;
                        blank_q <= blank_lz;
                        bcd     <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd, shreg} <= {bcd_adj, shreg} << 1;
                    cnt          <= cnt + 1'b1;
                end
                FMT: begin
                    char_ids <= fmt_ids;
                    overflow <= ov_nx;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
